// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NRD_DEF    = 2;

  // The encoding is fixed so that state_q doubles as "running".
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clearing sequencer. It walks every register address once, then hands over to RUN.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NREG - 1);

  rf_state_e       state_q;
  logic [ADDR_W:0] cnt_q;
  logic            done_q;

  // INIT clears one register per edge. done is registered together with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= ST_RUN;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign init_done = done_q;
  assign init_we   = (state_q == ST_INIT);
  assign init_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write port, a write-to-read bypass,
// a per-register pending scoreboard and a registered count of pending registers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int R0_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam bit R0Z  = (R0_ZERO != 0);

  logic                         run;
  logic                         init_we;
  logic [ADDR_W-1:0]            init_addr;
  logic [NREG-1:0][DATA_W-1:0]  mem_q;
  logic [NREG-1:0]              pend_q, pend_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;
  logic                         wr_ok;

  regfile_init_seq #(.ADDR_W(ADDR_W)) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (run),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign init_done = run;
  // Writes to reg 0 are dropped when it is hardwired to zero.
  assign wr_ok = run && wr_en && !(R0Z && (wr_addr == '0));

  // Storage: the sequencer zeroes it after reset, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if (init_we)    mem_q[init_addr] <= '0;
    else if (wr_ok) mem_q[wr_addr]   <= wr_data;
  end

  // Next pending vector. Issue is applied after writeback so a same-address issue wins.
  always_comb begin
    pend_d = pend_q;
    if (run) begin
      if (wr_en)  pend_d[wr_addr]  = 1'b0;
      if (iss_en) pend_d[iss_addr] = 1'b1;
    end
    if (R0Z) pend_d[0] = 1'b0;
  end

  // Popcount of the post-edge pending vector, registered as busy_cnt.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
  end

  // Scoreboard state. Reset drops every outstanding producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: reg 0 when hardwired beats the bypass, and the bypass beats storage.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp, zero;
    assign ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign byp  = wr_en && (wr_addr == ra);
    assign zero = !run || (R0Z && (ra == '0));
    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : (byp ? wr_data : mem_q[ra]);
    assign rd_busy[i] = !zero && pend_q[ra] && !byp;
  end

endmodule
